// File: rtl/custom_bus_mem_responder_if.sv
// Request/acknowledge bus between a custom_bus_master and a memory responder.
// The master drives the request side and the responder drives the acknowledge side.
interface custom_bus_mem_responder_if;
    logic       m_req;
    logic       m_r0_w1;
    logic [7:0] m_wr_data;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;
    logic       s_ack;
    logic       s_data_ack;
    logic       s_err;
    logic [7:0] m_rd_data;

    modport master (
        output m_req, m_r0_w1, m_wr_data, wr_addr, rd_addr,
        input  s_ack, s_data_ack, s_err, m_rd_data
    );

    modport slave (
        input  m_req, m_r0_w1, m_wr_data, wr_addr, rd_addr,
        output s_ack, s_data_ack, s_err, m_rd_data
    );
endinterface

// File: rtl/custom_bus_mem_responder.sv
// Register-backed memory target for the custom bus. It serves one access at a time,
// adds WAIT_CYCLES wait states between s_ack and s_data_ack, and flags addresses >= DEPTH.
module custom_bus_mem_responder #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    custom_bus_mem_responder_if.slave     bus,
    output logic [7:0]                    wr_count,
    output logic [7:0]                    rd_count
);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, ACK, WAIT, DATA} state_t;

    state_t     state;
    logic       lat_wr;
    logic [7:0] lat_addr;
    logic [7:0] lat_data;
    logic [3:0] wait_cnt;
    logic [7:0] mem [DEPTH];
    logic       addr_ok;

    assign addr_ok = ({1'b0, lat_addr} < 9'(DEPTH));

    // NOTE: every state bit, output and memory word sits in one non-blocking always_ff,
    // and the memory is cleared by the async reset because zero contents are observable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            lat_wr         <= 1'b0;
            lat_addr       <= 8'h00;
            lat_data       <= 8'h00;
            wait_cnt       <= 4'd0;
            bus.s_ack      <= 1'b0;
            bus.s_data_ack <= 1'b0;
            bus.s_err      <= 1'b0;
            bus.m_rd_data  <= 8'h00;
            wr_count       <= 8'h00;
            rd_count       <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            bus.s_ack      <= 1'b0;
            bus.s_data_ack <= 1'b0;
            bus.s_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_req) begin
                        lat_wr    <= bus.m_r0_w1;
                        lat_addr  <= bus.m_r0_w1 ? bus.wr_addr : bus.rd_addr;
                        lat_data  <= bus.m_wr_data;
                        bus.s_ack <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (WAIT_CYCLES > 0) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end else begin
                        bus.s_data_ack <= 1'b1;
                        bus.s_err      <= !addr_ok;
                        state          <= DATA;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        bus.s_data_ack <= 1'b1;
                        bus.s_err      <= !addr_ok;
                        state          <= DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DATA: begin
                    // Commit on leaving DATA; out-of-range reads return all ones.
                    if (lat_wr) begin
                        if (addr_ok) begin
                            mem[lat_addr[AW-1:0]] <= lat_data;
                            wr_count              <= wr_count + 8'd1;
                        end
                    end else if (addr_ok) begin
                        bus.m_rd_data <= mem[lat_addr[AW-1:0]];
                        rd_count      <= rd_count + 8'd1;
                    end else begin
                        bus.m_rd_data <= 8'hFF;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_custom_bus_mem_responder.sv
// Directed bench for custom_bus_mem_responder: one instance with two wait states
// and one with none, sharing clock and reset.
module tb_custom_bus_mem_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_count2, rd_count2, wr_count0, rd_count0;

    int n_checks = 0;
    int n_errors = 0;

    custom_bus_mem_responder_if bus2 ();
    custom_bus_mem_responder_if bus0 ();

    custom_bus_mem_responder #(.DEPTH(16), .WAIT_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus2),
        .wr_count (wr_count2),
        .rd_count (rd_count2)
    );

    custom_bus_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus0),
        .wr_count (wr_count0),
        .rd_count (rd_count0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_s_ack(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus2.s_ack && cyc < 20);
    endtask

    task automatic wait_s_data_ack(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus2.s_data_ack && cyc < 20);
    endtask

    // One full access on the two-wait-state instance; returns after the commit edge.
    task automatic access(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                          output int ack_c, output int dack_c, output logic err,
                          output logic [7:0] rdata);
        @(posedge clk); #1;
        bus2.m_req     = 1'b1;
        bus2.m_r0_w1   = wr;
        bus2.m_wr_data = data;
        if (wr) bus2.wr_addr = addr;
        else    bus2.rd_addr = addr;
        wait_s_ack(ack_c);
        bus2.m_req = 1'b0;
        wait_s_data_ack(dack_c);
        err = bus2.s_err;
        @(posedge clk); #1;
        rdata = bus2.m_rd_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         ack_c, dack_c, cyc;
        logic       err;
        logic [7:0] rdata;
        logic       dack_seen;
        logic [11:0] ack_vec, dack_vec;
        logic       err0_seen;

        {bus2.m_req, bus2.m_r0_w1, bus2.m_wr_data, bus2.wr_addr, bus2.rd_addr} = '0;
        {bus0.m_req, bus0.m_r0_w1, bus0.m_wr_data, bus0.wr_addr, bus0.rd_addr} = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ack", bus2.s_ack, 0);
        check("rst_s_data_ack", bus2.s_data_ack, 0);
        check("rst_s_err", bus2.s_err, 0);
        check("rst_rd_data", bus2.m_rd_data, 8'h00);
        check("rst_wr_count", wr_count2, 0);
        check("rst_rd_count", rd_count2, 0);
        rst = 1'b1;

        access(1'b1, 8'h03, 8'hA5, ack_c, dack_c, err, rdata);
        check("wr03_ack_lat", ack_c, 1);
        check("wr03_dack_lat", dack_c, 3);
        check("wr03_err", err, 0);
        check("wr03_wr_count", wr_count2, 1);

        access(1'b0, 8'h03, 8'h00, ack_c, dack_c, err, rdata);
        check("rd03_data", rdata, 8'hA5);
        check("rd03_rd_count", rd_count2, 1);

        access(1'b0, 8'h07, 8'h00, ack_c, dack_c, err, rdata);
        check("rd07_data", rdata, 8'h00);
        check("rd07_err", err, 0);
        check("rd07_rd_count", rd_count2, 2);

        access(1'b1, 8'h20, 8'h5A, ack_c, dack_c, err, rdata);
        check("wr20_err", err, 1);
        check("wr20_wr_count", wr_count2, 1);

        access(1'b0, 8'h20, 8'h00, ack_c, dack_c, err, rdata);
        check("rd20_data", rdata, 8'hFF);
        check("rd20_err", err, 1);
        check("rd20_rd_count", rd_count2, 2);

        // Reset asserted while the write of 8'h11 to 8'h02 is waiting.
        @(posedge clk); #1;
        bus2.m_req = 1'b1; bus2.m_r0_w1 = 1'b1; bus2.wr_addr = 8'h02; bus2.m_wr_data = 8'h11;
        @(posedge clk); #1;
        check("rstw_ack", bus2.s_ack, 1);
        bus2.m_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstw_s_ack", bus2.s_ack, 0);
        check("rstw_s_data_ack", bus2.s_data_ack, 0);
        check("rstw_rd_data", bus2.m_rd_data, 8'h00);
        check("rstw_wr_count", wr_count2, 0);
        check("rstw_rd_count", rd_count2, 0);
        dack_seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; dack_seen |= bus2.s_data_ack; end
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; dack_seen |= bus2.s_data_ack; end
        check("rstw_no_dack", dack_seen, 0);

        access(1'b0, 8'h02, 8'h00, ack_c, dack_c, err, rdata);
        check("rstw_rd02", rdata, 8'h00);
        access(1'b0, 8'h03, 8'h00, ack_c, dack_c, err, rdata);
        check("rstw_rd03_cleared", rdata, 8'h00);

        // 256 writes: address i mod 16, data i.
        for (int i = 0; i < 256; i++) begin
            access(1'b1, 8'(i % 16), 8'(i), ack_c, dack_c, err, rdata);
            if (i == 254) check("wr255_count", wr_count2, 8'hFF);
        end
        check("wr256_wrap", wr_count2, 8'h00);
        access(1'b0, 8'h05, 8'h00, ack_c, dack_c, err, rdata);
        check("rd05_last", rdata, 8'hF5);

        // Bus inputs toggled during WAIT must not affect the latched write.
        @(posedge clk); #1;
        bus2.m_req = 1'b1; bus2.m_r0_w1 = 1'b1; bus2.wr_addr = 8'h09; bus2.m_wr_data = 8'h3C;
        wait_s_ack(cyc);
        check("tog_ack_lat", cyc, 1);
        bus2.m_req = 1'b0;
        @(posedge clk); #1;
        bus2.wr_addr = 8'h0A; bus2.m_wr_data = 8'hC3; bus2.m_r0_w1 = 1'b0; bus2.rd_addr = 8'h0A;
        wait_s_data_ack(cyc);
        check("tog_dack_lat", cyc, 2);
        @(posedge clk); #1;
        check("tog_wr_count", wr_count2, 1);
        access(1'b0, 8'h09, 8'h00, ack_c, dack_c, err, rdata);
        check("tog_rd09", rdata, 8'h3C);
        access(1'b0, 8'h0A, 8'h00, ack_c, dack_c, err, rdata);
        check("tog_rd0A", rdata, 8'hFA);

        // Zero wait states, request held high: a transaction every 3 cycles.
        @(posedge clk); #1;
        bus0.m_req = 1'b1; bus0.m_r0_w1 = 1'b0; bus0.rd_addr = 8'h01;
        ack_vec = '0; dack_vec = '0; err0_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            ack_vec[k]  = bus0.s_ack;
            dack_vec[k] = bus0.s_data_ack;
            err0_seen  |= bus0.s_err;
        end
        bus0.m_req = 1'b0;
        check("w0_ack_pattern", ack_vec, 12'h249);
        check("w0_dack_pattern", dack_vec, 12'h492);
        check("w0_no_err", err0_seen, 0);
        check("w0_rd_count", rd_count0, 4);
        check("w0_rd_data", bus0.m_rd_data, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/custom_bus_mem_responder.md
# custom_bus_mem_responder

Memory-backed responder for the custom bus: the target-side end of the `m_req`/`s_ack`/`s_data_ack` handshake issued by `custom_bus_master`. It accepts one read or write at a time into a register-based memory of `DEPTH` bytes. It inserts a programmable number of wait states between the request acknowledge and the data acknowledge, and it flags out-of-range addresses. It is the drop-in target for master-side benches and for system integration where the slave must model real access latency.

## Interface
- `DEPTH`, 16: number of 8-bit memory locations; power of two, 2..256.
- `WAIT_CYCLES`, 2: wait states between the `s_ack` cycle and the `s_data_ack` cycle; 0..15.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = in reset); one clock, no other reset.
- `m_req` input 1: request from master; level, held until `s_ack` is seen.
- `m_r0_w1` input 1: 0 = read, 1 = write; valid while `m_req` = 1.
- `m_wr_data` input 8: write data; valid while `m_req` = 1 and `m_r0_w1` = 1.
- `wr_addr` input 8: write address; valid with a write request.
- `rd_addr` input 8: read address; valid with a read request.
- `s_ack` output 1: one-cycle pulse; request accepted and inputs latched.
- `s_data_ack` output 1: one-cycle pulse; access complete.
- `m_rd_data` output 8: read data; updated only on read completion and held until the next read completion.
- `s_err` output 1: one-cycle pulse coincident with `s_data_ack` when the latched address is >= `DEPTH`.
- `wr_count` output 8: completed in-range writes, wraps 255 -> 0.
- `rd_count` output 8: completed in-range reads, wraps 255 -> 0.

## Operation
- FSM states: IDLE, ACK, WAIT, DATA. The reset state is IDLE.
- **IDLE:** when `m_req` = 1 at a rising edge, latch `m_r0_w1`, the selected address, and `m_wr_data`, then go to ACK. The selected address is `wr_addr` for a write and `rd_addr` for a read. The unused address port is ignored.
- **ACK:** `s_ack` = 1 for exactly this cycle. Next state is WAIT if `WAIT_CYCLES` > 0, otherwise DATA.
- **WAIT:** a 4-bit counter counts `WAIT_CYCLES` cycles. The transition to DATA occurs on the edge that ends the last wait cycle. `m_req` is ignored here.
- **DATA:** `s_data_ack` = 1 for exactly this cycle. The access commits on the edge that leaves DATA.
  - In-range write: `mem[addr] <= data`; `wr_count` increments.
  - In-range read: `m_rd_data <= mem[addr]`; `rd_count` increments.
  - Out-of-range (addr >= `DEPTH`): no memory write and no counter change. `s_err` = 1 in this cycle, and a read loads `m_rd_data <= 8'hFF`.
  - Next state is always IDLE.
- `m_req` is sampled only in IDLE. A request still high in the IDLE cycle after DATA is treated as a new request.
- Latched inputs are frozen from ACK through DATA. Changes on the bus inputs during a transaction have no effect.
- Memory, counters and `m_rd_data` are registers. Every memory word resets to 8'h00.

## Timing
- Reset (`rst` = 0), asynchronous and immediate:
  - State returns to IDLE.
  - `s_ack`, `s_data_ack` and `s_err` are 0.
  - `m_rd_data`, `wr_count` and `rd_count` are 8'h00.
  - All memory words are 8'h00.
  - A transaction in flight is aborted with no write commit and no `s_data_ack`.
- First request sampled on the first rising edge after `rst` deasserts.
- `m_req` sampled high at edge N:
  - `s_ack` is high during cycle N..N+1.
  - `s_data_ack` is high during cycle N+1+`WAIT_CYCLES`..N+2+`WAIT_CYCLES`.
- Read data is visible on `m_rd_data` the cycle after the `s_data_ack` cycle. The master samples it one cycle after `s_data_ack`.
- Minimum request-to-request spacing is `WAIT_CYCLES`+3 cycles. Back-to-back requests need no idle cycle beyond the IDLE sample.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.

## Test plan
- Reset, then write 8'hA5 to `wr_addr` 8'h03 (`WAIT_CYCLES` = 2):
  - `s_ack` arrives 1 cycle after `m_req` is sampled.
  - `s_data_ack` arrives 3 cycles after `s_ack`.
  - `wr_count` = 1.
  - A read of `rd_addr` 8'h03 returns 8'hA5, with `rd_count` = 1.
- Read of an unwritten in-range address 8'h07 after reset -> `m_rd_data` = 8'h00, `s_err` = 0.
- Write 8'h5A to `wr_addr` 8'h20 with `DEPTH` = 16:
  - `s_err` pulses with `s_data_ack` and `wr_count` is unchanged.
  - A subsequent read of `rd_addr` 8'h20 returns 8'hFF with `s_err` = 1.
- `WAIT_CYCLES` = 0: `s_data_ack` immediately follows `s_ack`. Hold `m_req` high continuously: a new transaction starts every 3 cycles, and `rd_count` reaches 4 after 12 cycles of reads.
- Assert `rst` low during WAIT of a write of 8'h11 to 8'h02:
  - Outputs clear immediately and no `s_data_ack` is issued.
  - After reset, reading 8'h02 returns 8'h00.
- Issue 256 in-range writes -> `wr_count` wraps to 8'h00. Toggle `wr_addr`/`m_wr_data` during WAIT -> the originally latched values are the ones written.
